// File: rtl/scsi_slave_seq_if.sv
// CPU-side slave request and NCR 53C710 strobe bundle for scsi_slave_seq.
// The slave modport is the sequencer's view; master is the requester/bus side.
interface scsi_slave_seq_if;
    logic       slave_cycle;
    logic       MASTER;
    logic       READ;
    logic [3:0] DS_n;
    logic       SCSI_STERM_n;
    logic       SCSI_AS_n;
    logic       SCSI_DS_n;
    logic       SCSI_SREG_n;
    logic [1:0] SIZ;
    logic [1:0] ADDRL;
    logic       slave_ack;
    logic       slave_berr;
    logic       busy;

    modport slave (
        input  slave_cycle, MASTER, READ, DS_n, SCSI_STERM_n,
        output SCSI_AS_n, SCSI_DS_n, SCSI_SREG_n, SIZ, ADDRL,
               slave_ack, slave_berr, busy
    );

    modport master (
        output slave_cycle, MASTER, READ, DS_n, SCSI_STERM_n,
        input  SCSI_AS_n, SCSI_DS_n, SCSI_SREG_n, SIZ, ADDRL,
               slave_ack, slave_berr, busy
    );
endinterface

// File: rtl/scsi_slave_seq.sv
// CPU-to-NCR 53C710 slave-access sequencer with programmable setup, data-strobe
// delay, hold and timeout; terminates on STERM_n (ack) or timeout (berr).
module scsi_slave_seq #(
    parameter int SETUP_CLKS   = 1,
    parameter int DS_DELAY     = 1,
    parameter int HOLD_CLKS    = 1,
    parameter int TIMEOUT_CLKS = 64,
    parameter int SYNC_STERM   = 1
) (
    input logic             CLK,
    input logic             IORST,
    scsi_slave_seq_if.slave bus
);

    localparam int CMAX0 = (SETUP_CLKS > HOLD_CLKS) ? SETUP_CLKS : HOLD_CLKS;
    localparam int CMAX  = (CMAX0 > DS_DELAY) ? CMAX0 : DS_DELAY;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int TW    = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CLKS - 1);
    localparam logic [CW-1:0] DS_LAST    = CW'((DS_DELAY > 0) ? DS_DELAY - 1 : 0);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CLKS - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_ACK,
        S_ERR,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          rd_q, rd_d;
    logic          pend_q, pend_d;
    logic          sync1_q, sync2_q;
    logic          as_q, as_d;
    logic          ds_q, ds_d;
    logic          sreg_q, sreg_d;
    logic [1:0]    siz_q, siz_d;
    logic [1:0]    addrl_q, addrl_d;
    logic          ack_q, ack_d;
    logic          berr_q, berr_d;
    logic          busy_q, busy_d;

    logic          sterm_low;
    logic [1:0]    dec_siz;
    logic [1:0]    dec_addrl;
    logic          term_hit;
    logic          to_hit;

    assign sterm_low = (SYNC_STERM != 0) ? ~sync2_q : ~bus.SCSI_STERM_n;

    // Only contiguous byte-lane groups map to a size; anything else falls back to long.
    always_comb begin
        dec_siz   = 2'b00;
        dec_addrl = 2'b00;
        case (bus.DS_n)
            4'b0011: begin dec_siz = 2'b10; dec_addrl = 2'b00; end
            4'b1100: begin dec_siz = 2'b10; dec_addrl = 2'b10; end
            4'b0111: begin dec_siz = 2'b01; dec_addrl = 2'b00; end
            4'b1011: begin dec_siz = 2'b01; dec_addrl = 2'b01; end
            4'b1101: begin dec_siz = 2'b01; dec_addrl = 2'b10; end
            4'b1110: begin dec_siz = 2'b01; dec_addrl = 2'b11; end
            4'b0001: begin dec_siz = 2'b11; dec_addrl = 2'b00; end
            4'b1000: begin dec_siz = 2'b11; dec_addrl = 2'b01; end
            default: begin dec_siz = 2'b00; dec_addrl = 2'b00; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        to_cnt_d = to_cnt_q;
        rd_d     = rd_q;
        pend_d   = pend_q;
        siz_d    = siz_q;
        addrl_d  = addrl_q;
        as_d     = 1'b1;
        ds_d     = 1'b1;
        ack_d    = 1'b0;
        berr_d   = 1'b0;
        // STERM latched earlier (pend_q) still terminates once DS is on the bus.
        term_hit = ~ds_q & (sterm_low | pend_q);
        to_hit   = (TIMEOUT_CLKS != 0) && (to_cnt_q == TO_LAST);

        case (state_q)
            S_IDLE: begin
                if (bus.slave_cycle && !bus.MASTER && (bus.DS_n != 4'hF)) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    rd_d    = bus.READ;
                    siz_d   = dec_siz;
                    addrl_d = dec_addrl;
                end
            end
            S_SETUP: begin
                if (!bus.slave_cycle) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d  = S_STROBE;
                    cnt_d    = '0;
                    to_cnt_d = '0;
                    pend_d   = 1'b0;
                    as_d     = 1'b0;
                    ds_d     = ~(rd_q || (DS_DELAY == 0));
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE: begin
                if (term_hit) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                end else if (to_hit) begin
                    state_d = S_ERR;
                    berr_d  = 1'b1;
                end else if (!bus.slave_cycle) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    as_d     = 1'b0;
                    to_cnt_d = to_cnt_q + TW'(1);
                    pend_d   = pend_q | sterm_low;
                    if (!ds_q || (cnt_q == DS_LAST)) begin
                        ds_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_ACK, S_ERR: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    if (!bus.slave_cycle) state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        sreg_d = as_d;
        busy_d = (state_d != S_IDLE);
    end

    // Sync flops reset to the negated level so reset never fakes a termination.
    always_ff @(posedge CLK) begin
        if (IORST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            rd_q     <= 1'b0;
            pend_q   <= 1'b0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            as_q     <= 1'b1;
            ds_q     <= 1'b1;
            sreg_q   <= 1'b1;
            siz_q    <= '0;
            addrl_q  <= '0;
            ack_q    <= 1'b0;
            berr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
            rd_q     <= rd_d;
            pend_q   <= pend_d;
            sync1_q  <= bus.SCSI_STERM_n;
            sync2_q  <= sync1_q;
            as_q     <= as_d;
            ds_q     <= ds_d;
            sreg_q   <= sreg_d;
            siz_q    <= siz_d;
            addrl_q  <= addrl_d;
            ack_q    <= ack_d;
            berr_q   <= berr_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.SCSI_AS_n   = as_q;
    assign bus.SCSI_DS_n   = ds_q;
    assign bus.SCSI_SREG_n = sreg_q;
    assign bus.SIZ         = siz_q;
    assign bus.ADDRL       = addrl_q;
    assign bus.slave_ack   = ack_q;
    assign bus.slave_berr  = berr_q;
    assign bus.busy        = busy_q;

endmodule
